wb_initiator_bridge: RTL

- Wishbone classic (B4, non-pipelined) initiator that converts a simple valid/ready command stream into single Wishbone read/write cycles.
- Returns each result on a valid/ready response stream.
- Sits inside the user project and drives peripheral Wishbone responders, i.e. the initiator end of the same bus the management SoC uses toward the user area.
- Exactly one transaction is outstanding at a time; a timeout converts a hung responder into an error response.

---
 rtl/wb_initiator_bridge.sv | 120 ++++++++++++
 1 files changed

// File: rtl/wb_initiator_bridge.sv
// rtl/wb_initiator_bridge.sv - Wishbone classic initiator bridging a cmd/rsp valid-ready stream pair
module wb_initiator_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_sel,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [DATA_W/8-1:0]   wbm_sel_o,
    output logic [ADDR_W-1:0]     wbm_adr_o,
    output logic [DATA_W-1:0]     wbm_dat_o,
    input  logic [DATA_W-1:0]     wbm_dat_i,
    input  logic                  wbm_ack_i,
    output logic                  busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    // Gated by reset so that every output reads 0 while reset is held.
    assign cmd_ready = (state == IDLE) && wb_rst_ni;
    assign busy      = (state != IDLE);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = BUS;
            BUS:     if (wbm_ack_i || timeout_hit) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= cmd_we;
                        wbm_sel_o <= cmd_sel;
                        wbm_adr_o <= cmd_addr;
                        wbm_dat_o <= cmd_wdata;
                        cnt       <= '0;
                    end
                end
                BUS: begin
                    // An ack on the timeout edge still completes the cycle normally.
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        rsp_rdata <= wbm_we_o ? '0 : wbm_dat_i;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else if (timeout_hit) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
